// File: rtl/spi_resp_pkg.sv
// spi_resp_pkg: shared constants, types and helpers for the SPI responder.
//   BYTE_W / BITCNT_W     : data width and bit-counter width
//   FIFO_DEPTH / FIFO_PTR_W: optional RX FIFO geometry (SPI_RESP_RXFIFO_EN)
//   IDLE_FILL_DEFAULT     : byte shifted out when no TX byte is queued
//   state_t               : frame state encoding (ST_IDLE / ST_ACTIVE)
package spi_resp_pkg;

  localparam int BYTE_W     = 8;
  localparam int BITCNT_W   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;

  localparam logic [BYTE_W-1:0]     IDLE_FILL_DEFAULT = 8'hFF;
  localparam logic [BITCNT_W-1:0]   BIT_LAST          = 4'd7;
  localparam logic [BITCNT_W-1:0]   BIT_DONE          = 4'd8;
  localparam logic [FIFO_PTR_W:0]   FIFO_FULL_CNT     = 3'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Byte to load into the TX shifter: the queued byte, or the fill pattern
  // when nothing is queued.
  function automatic logic [BYTE_W-1:0] next_tx_byte(
    input logic              hold_empty,
    input logic [BYTE_W-1:0] hold,
    input logic [BYTE_W-1:0] fill
  );
    logic [BYTE_W-1:0] result;
    if (hold_empty) begin
      result = fill;
    end else begin
      result = hold;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_resp_sync.sv
// spi_resp_sync: multi-flop synchronizer with edge detection on the
// synchronized copy.
//   clk, rst_n : local clock, asynchronous active-low reset
//   din        : asynchronous input
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized transitions
// Parameters: STAGES (flop count, 2..3), RESET_VAL (idle level of din so
// that reset release does not fabricate an edge).
module spi_resp_sync #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RESET_VAL}};
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = sync_r[STAGES-1] & ~prev_r;
  assign fall  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_responder.sv
// spi_responder: oversampling SPI target (mode 0 / mode 2, CPHA=0, MSB first)
// with a byte-level handshake to local logic.
//   CLK, nRESET                 : local clock, asynchronous active-low reset
//   SCK, MOSI, nSS              : SPI bus from the master (asynchronous)
//   MISO, MISO_OE               : SPI return data and its pad enable
//   RX_DATA, RX_VALID, RX_READ  : received byte, unread flag, pop/acknowledge
//   TX_DATA, TX_WRITE, TX_EMPTY : next byte to send, load strobe, holding free
//   OVERRUN, UNDERRUN, ERR_CLR  : sticky error flags and their clear
// Build option: define SPI_RESP_RXFIFO_EN to buffer received bytes in a
// 4-entry FIFO instead of a single holding register.
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter bit                CPOL        = 1'b0,
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] IDLE_FILL   = IDLE_FILL_DEFAULT
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              nSS,
  output logic              MISO,
  output logic              MISO_OE,
  output logic [BYTE_W-1:0] RX_DATA,
  output logic              RX_VALID,
  input  logic              RX_READ,
  input  logic [BYTE_W-1:0] TX_DATA,
  input  logic              TX_WRITE,
  output logic              TX_EMPTY,
  output logic              OVERRUN,
  output logic              UNDERRUN,
  input  logic              ERR_CLR
);

  // Synchronized bus signals
  logic sck_level_unused_s, sck_rise_s, sck_fall_s;
  logic nss_level_unused_s, nss_rise_s, nss_fall_s;
  logic mosi_level_s, mosi_rise_unused_s, mosi_fall_unused_s;

  spi_resp_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sck (
    .clk   (CLK),
    .rst_n (nRESET),
    .din   (SCK),
    .level (sck_level_unused_s),
    .rise  (sck_rise_s),
    .fall  (sck_fall_s)
  );

  spi_resp_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nss (
    .clk   (CLK),
    .rst_n (nRESET),
    .din   (nSS),
    .level (nss_level_unused_s),
    .rise  (nss_rise_s),
    .fall  (nss_fall_s)
  );

  spi_resp_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (CLK),
    .rst_n (nRESET),
    .din   (MOSI),
    .level (mosi_level_s),
    .rise  (mosi_rise_unused_s),
    .fall  (mosi_fall_unused_s)
  );

  // State
  state_t              state_r;
  logic [BITCNT_W-1:0] bit_cnt_r;
  logic [BYTE_W-1:0]   tx_shift_r;   // MSB is the MISO pin value
  logic [BYTE_W-2:0]   rx_shift_r;   // only 7 bits kept; 8th goes straight out
  logic                miso_oe_r;
  logic [BYTE_W-1:0]   tx_hold_r;
  logic                tx_empty_r;
  logic                overrun_r;
  logic                underrun_r;

  // Decoded events
  logic              lead_s;
  logic              trail_s;
  logic              start_s;
  logic              stop_s;
  logic              run_s;
  logic              byte_done_s;
  logic              reload_s;
  logic              tx_accept_s;
  logic              underrun_set_s;
  logic              overrun_set_s;
  logic [BYTE_W-1:0] reload_byte_s;
  logic [BYTE_W-1:0] rx_byte_s;

  // Event decode: SCK edge direction by polarity, frame start/stop, reloads.
  always_comb begin
    lead_s  = 1'b0;
    trail_s = 1'b0;
    if (CPOL) begin
      lead_s  = sck_fall_s;
      trail_s = sck_rise_s;
    end else begin
      lead_s  = sck_rise_s;
      trail_s = sck_fall_s;
    end
    start_s        = (state_r == ST_IDLE) && nss_fall_s;
    stop_s         = (state_r == ST_ACTIVE) && nss_rise_s;
    // A deselect in the same cycle as an SCK edge wins over the edge.
    run_s          = (state_r == ST_ACTIVE) && !nss_rise_s;
    byte_done_s    = run_s && lead_s && (bit_cnt_r == BIT_LAST);
    reload_s       = start_s || (run_s && trail_s && (bit_cnt_r == BIT_DONE));
    reload_byte_s  = next_tx_byte(tx_empty_r, tx_hold_r, IDLE_FILL);
    rx_byte_s      = {rx_shift_r, mosi_level_s};
    // A reload frees the holding register in the same cycle, so a
    // coincident write lands behind it.
    tx_accept_s    = TX_WRITE && (tx_empty_r || reload_s);
    underrun_set_s = reload_s && tx_empty_r;
  end

  // Frame state machine: bit counting, TX shifting and MISO drive.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 4'd0;
      tx_shift_r <= 8'hFF;
      rx_shift_r <= 7'd0;
      miso_oe_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r    <= ST_ACTIVE;
            bit_cnt_r  <= 4'd0;
            tx_shift_r <= reload_byte_s;
            miso_oe_r  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (stop_s) begin
            // Partial bytes in either direction are discarded.
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            tx_shift_r <= 8'hFF;
            miso_oe_r  <= 1'b0;
          end else if (lead_s && (bit_cnt_r != BIT_DONE)) begin
            rx_shift_r <= rx_byte_s[BYTE_W-2:0];
            bit_cnt_r  <= bit_cnt_r + 4'd1;
          end else if (trail_s) begin
            if (bit_cnt_r == BIT_DONE) begin
              tx_shift_r <= reload_byte_s;
              bit_cnt_r  <= 4'd0;
            end else begin
              tx_shift_r <= {tx_shift_r[BYTE_W-2:0], 1'b1};
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          bit_cnt_r  <= 4'd0;
          tx_shift_r <= 8'hFF;
          miso_oe_r  <= 1'b0;
        end
      endcase
    end
  end

  // TX holding register: host writes and consumption by reloads.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      tx_hold_r  <= 8'h00;
      tx_empty_r <= 1'b1;
    end else if (tx_accept_s) begin
      tx_hold_r  <= TX_DATA;
      tx_empty_r <= 1'b0;
    end else if (reload_s) begin
      tx_empty_r <= 1'b1;
    end
  end

`ifdef SPI_RESP_RXFIFO_EN
  logic [BYTE_W-1:0]   fifo_mem_r [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_r;
  logic [FIFO_PTR_W-1:0] rd_ptr_r;
  logic [FIFO_PTR_W:0]   count_r;
  logic                  fifo_full_s;
  logic                  pop_s;
  logic                  push_s;

  // FIFO control: a pop in the same cycle makes room for a push when full.
  always_comb begin
    fifo_full_s   = (count_r == FIFO_FULL_CNT);
    pop_s         = RX_READ && (count_r != 3'd0);
    push_s        = byte_done_s && (!fifo_full_s || pop_s);
    overrun_set_s = byte_done_s && fifo_full_s && !pop_s;
  end

  // RX FIFO storage, pointers and occupancy.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= rx_byte_s;
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign RX_DATA  = fifo_mem_r[rd_ptr_r];
  assign RX_VALID = (count_r != 3'd0);
`else
  logic [BYTE_W-1:0] rx_data_r;
  logic              rx_valid_r;

  // A new byte is dropped only if the previous one is unread and not being
  // acknowledged in the same cycle.
  always_comb begin
    overrun_set_s = byte_done_s && rx_valid_r && !RX_READ;
  end

  // RX holding register and its unread flag.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
    end else if (byte_done_s && (!rx_valid_r || RX_READ)) begin
      rx_data_r  <= rx_byte_s;
      rx_valid_r <= 1'b1;
    end else if (RX_READ) begin
      rx_valid_r <= 1'b0;
    end
  end

  assign RX_DATA  = rx_data_r;
  assign RX_VALID = rx_valid_r;
`endif

  // Sticky error flags; a new error event beats a simultaneous clear.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (ERR_CLR) begin
        overrun_r <= 1'b0;
      end
      if (underrun_set_s) begin
        underrun_r <= 1'b1;
      end else if (ERR_CLR) begin
        underrun_r <= 1'b0;
      end
    end
  end

  assign MISO     = tx_shift_r[BYTE_W-1];
  assign MISO_OE  = miso_oe_r;
  assign TX_EMPTY = tx_empty_r;
  assign OVERRUN  = overrun_r;
  assign UNDERRUN = underrun_r;

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed bench for spi_responder. Two instances share
// the local clock and reset: dut0 uses CPOL=0 (mode 0), dut1 uses CPOL=1
// (mode 2). A bit-banged master drives SCK at 8 CLK cycles per bit.
module tb_spi_responder;

  logic       clk = 1'b0;
  logic       nreset;
  logic       sck0, sck1, mosi, nss0, nss1;
  logic       rx_read, err_clr, tx_write0, tx_write1;
  logic [7:0] tx_data;

  logic       miso0, miso_oe0, rx_valid0, tx_empty0, overrun0, underrun0;
  logic       miso1, miso_oe1, rx_valid1, tx_empty1, overrun1, underrun1;
  logic [7:0] rx_data0, rx_data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_responder #(.CPOL(1'b0)) dut0 (
    .CLK(clk), .nRESET(nreset), .SCK(sck0), .MOSI(mosi), .nSS(nss0),
    .MISO(miso0), .MISO_OE(miso_oe0), .RX_DATA(rx_data0), .RX_VALID(rx_valid0),
    .RX_READ(rx_read), .TX_DATA(tx_data), .TX_WRITE(tx_write0), .TX_EMPTY(tx_empty0),
    .OVERRUN(overrun0), .UNDERRUN(underrun0), .ERR_CLR(err_clr)
  );

  spi_responder #(.CPOL(1'b1)) dut1 (
    .CLK(clk), .nRESET(nreset), .SCK(sck1), .MOSI(mosi), .nSS(nss1),
    .MISO(miso1), .MISO_OE(miso_oe1), .RX_DATA(rx_data1), .RX_VALID(rx_valid1),
    .RX_READ(rx_read), .TX_DATA(tx_data), .TX_WRITE(tx_write1), .TX_EMPTY(tx_empty1),
    .OVERRUN(overrun1), .UNDERRUN(underrun1), .ERR_CLR(err_clr)
  );

  task automatic host_write(input bit which, input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    if (which) tx_write1 = 1'b1; else tx_write0 = 1'b1;
    @(negedge clk);
    tx_write0 = 1'b0;
    tx_write1 = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) begin
      if (rx_valid0) pop();
    end
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic select(input bit which);
    @(negedge clk);
    if (which) nss1 = 1'b0; else nss0 = 1'b0;
    #40;
  endtask

  task automatic deselect(input bit which);
    #40;
    if (which) nss1 = 1'b1; else nss0 = 1'b1;
    #40;
    if (which) sck1 = 1'b1; else sck0 = 1'b0;
    #80;
  endtask

  // Master shifts nbits of tx; samples MISO at each leading edge. With
  // hold_last the final trailing edge is withheld until deselect.
  task automatic spi_byte(input bit which, input logic [7:0] tx, input int nbits,
                          input bit hold_last, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      #40;
      rx = {rx[6:0], (which ? miso1 : miso0)};
      if (which) sck1 = 1'b0; else sck0 = 1'b1;
      #40;
      if (!(hold_last && (i == nbits - 1))) begin
        if (which) sck1 = 1'b1; else sck0 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    #20;
    checks++; if (miso0 !== 1'b1) begin errors++; $display("FAIL reset_miso0: got %b expected 1", miso0); end
    checks++; if (miso_oe0 !== 1'b0) begin errors++; $display("FAIL reset_oe0: got %b expected 0", miso_oe0); end
    checks++; if (rx_data0 !== 8'h00) begin errors++; $display("FAIL reset_rxdata0: got %h expected 00", rx_data0); end
    checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL reset_rxvalid0: got %b expected 0", rx_valid0); end
    checks++; if (tx_empty0 !== 1'b1) begin errors++; $display("FAIL reset_txempty0: got %b expected 1", tx_empty0); end
    checks++; if ({overrun0, underrun0} !== 2'b00) begin errors++; $display("FAIL reset_err0: got %b expected 00", {overrun0, underrun0}); end
    checks++; if ({miso1, miso_oe1, rx_valid1, tx_empty1} !== 4'b1001) begin errors++; $display("FAIL reset_dut1: got %b expected 1001", {miso1, miso_oe1, rx_valid1, tx_empty1}); end
    @(negedge clk);
    nreset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] rd;
    host_write(1'b0, 8'hA5);
    checks++; if (tx_empty0 !== 1'b0) begin errors++; $display("FAIL basic_txfull: got %b expected 0", tx_empty0); end
    select(1'b0);
    checks++; if (miso_oe0 !== 1'b1) begin errors++; $display("FAIL basic_oe: got %b expected 1", miso_oe0); end
    checks++; if (tx_empty0 !== 1'b1) begin errors++; $display("FAIL basic_txconsumed: got %b expected 1", tx_empty0); end
    spi_byte(1'b0, 8'h3C, 8, 1'b1, rd);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL basic_miso: got %h expected a5", rd); end
    checks++; if (rx_data0 !== 8'h3C) begin errors++; $display("FAIL basic_rxdata: got %h expected 3c", rx_data0); end
    checks++; if (rx_valid0 !== 1'b1) begin errors++; $display("FAIL basic_rxvalid: got %b expected 1", rx_valid0); end
    checks++; if (underrun0 !== 1'b0) begin errors++; $display("FAIL basic_underrun: got %b expected 0", underrun0); end
    deselect(1'b0);
    checks++; if ({miso_oe0, miso0} !== 2'b01) begin errors++; $display("FAIL basic_idle_pins: got %b expected 01", {miso_oe0, miso0}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd1, rd2;
    drain();
    select(1'b0);
    checks++; if (underrun0 !== 1'b1) begin errors++; $display("FAIL b2b_underrun: got %b expected 1", underrun0); end
    spi_byte(1'b0, 8'h01, 8, 1'b0, rd1);
    spi_byte(1'b0, 8'h02, 8, 1'b1, rd2);
    checks++; if (rd1 !== 8'hFF) begin errors++; $display("FAIL b2b_fill1: got %h expected ff", rd1); end
    checks++; if (rd2 !== 8'hFF) begin errors++; $display("FAIL b2b_fill2: got %h expected ff", rd2); end
    checks++; if (rx_data0 !== 8'h01) begin errors++; $display("FAIL b2b_rxdata: got %h expected 01", rx_data0); end
`ifdef SPI_RESP_RXFIFO_EN
    checks++; if (overrun0 !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun0); end
`else
    checks++; if (overrun0 !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", overrun0); end
`endif
    deselect(1'b0);
    clear_err();
    checks++; if ({overrun0, underrun0} !== 2'b00) begin errors++; $display("FAIL err_clr: got %b expected 00", {overrun0, underrun0}); end
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    drain();
    host_write(1'b0, 8'h3E);
    select(1'b0);
    spi_byte(1'b0, 8'hF0, 5, 1'b0, rd);
    deselect(1'b0);
    checks++; if (tx_empty0 !== 1'b1) begin errors++; $display("FAIL abort_txempty: got %b expected 1", tx_empty0); end
    checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL abort_rxvalid: got %b expected 0", rx_valid0); end
    checks++; if (miso_oe0 !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b expected 0", miso_oe0); end
    host_write(1'b0, 8'h24);
    host_write(1'b0, 8'h99);   // holding register full: must be ignored
    select(1'b0);
    spi_byte(1'b0, 8'h81, 8, 1'b1, rd);
    checks++; if (rd !== 8'h24) begin errors++; $display("FAIL abort_ignored_write: got %h expected 24", rd); end
    checks++; if (rx_data0 !== 8'h81) begin errors++; $display("FAIL abort_rxdata: got %h expected 81", rx_data0); end
    checks++; if (rx_valid0 !== 1'b1) begin errors++; $display("FAIL abort_rxvalid2: got %b expected 1", rx_valid0); end
    deselect(1'b0);
  endtask

  task automatic test_cpol1();
    logic [7:0] rd;
    host_write(1'b1, 8'h69);
    select(1'b1);
    spi_byte(1'b1, 8'h96, 8, 1'b1, rd);
    checks++; if (rd !== 8'h69) begin errors++; $display("FAIL cpol1_miso: got %h expected 69", rd); end
    checks++; if (rx_data1 !== 8'h96) begin errors++; $display("FAIL cpol1_rxdata: got %h expected 96", rx_data1); end
    checks++; if ({rx_valid1, underrun1} !== 2'b10) begin errors++; $display("FAIL cpol1_flags: got %b expected 10", {rx_valid1, underrun1}); end
    deselect(1'b1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    host_write(1'b0, 8'h11);
    select(1'b0);
    spi_byte(1'b0, 8'hC3, 4, 1'b0, rd);
    #2;
    nreset = 1'b0;
    #1;
    checks++; if ({miso0, miso_oe0, rx_valid0, tx_empty0} !== 4'b1001) begin errors++; $display("FAIL rstmid_pins: got %b expected 1001", {miso0, miso_oe0, rx_valid0, tx_empty0}); end
    checks++; if (rx_data0 !== 8'h00) begin errors++; $display("FAIL rstmid_rxdata: got %h expected 00", rx_data0); end
    checks++; if ({overrun0, underrun0} !== 2'b00) begin errors++; $display("FAIL rstmid_err: got %b expected 00", {overrun0, underrun0}); end
    nss0 = 1'b1;
    sck0 = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    repeat (4) @(negedge clk);
    host_write(1'b0, 8'hC3);
    select(1'b0);
    spi_byte(1'b0, 8'h5A, 8, 1'b1, rd);
    checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL rstmid_miso: got %h expected c3", rd); end
    checks++; if (rx_data0 !== 8'h5A) begin errors++; $display("FAIL rstmid_rxdata2: got %h expected 5a", rx_data0); end
    deselect(1'b0);
  endtask

`ifdef SPI_RESP_RXFIFO_EN
  task automatic test_fifo();
    logic [7:0] rd;
    logic [7:0] b;
    drain();
    select(1'b0);
    for (int i = 0; i < 5; i++) begin
      b = 8'h10 + 8'(i);
      spi_byte(1'b0, b, 8, (i == 4), rd);
    end
    deselect(1'b0);
    checks++; if (overrun0 !== 1'b1) begin errors++; $display("FAIL fifo_overrun: got %b expected 1", overrun0); end
    for (int i = 0; i < 4; i++) begin
      b = 8'h10 + 8'(i);
      checks++; if ({rx_valid0, rx_data0} !== {1'b1, b}) begin errors++; $display("FAIL fifo_pop%0d: got %b/%h expected 1/%h", i, rx_valid0, rx_data0, b); end
      pop();
    end
    checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL fifo_empty: got %b expected 0", rx_valid0); end
  endtask
`endif

  initial begin
    nreset    = 1'b0;
    sck0      = 1'b0;
    sck1      = 1'b1;
    mosi      = 1'b0;
    nss0      = 1'b1;
    nss1      = 1'b1;
    rx_read   = 1'b0;
    err_clr   = 1'b0;
    tx_write0 = 1'b0;
    tx_write1 = 1'b0;
    tx_data   = 8'h00;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_cpol1();
    test_reset_mid();
`ifdef SPI_RESP_RXFIFO_EN
    test_fifo();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
